// File: rtl/fp16_sched_pkg.sv
// Shared types and constants for the fp16 multiplier scheduler.
// Tag and response ids are sized for the largest supported requester count.
package fp16_sched_pkg;

  localparam int unsigned FP16_W   = 16;
  localparam int unsigned ID_MAX_W = 3;

  function automatic int unsigned id_w(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [FP16_W-1:0]   x;
  } rsp_t;

endpackage

// File: rtl/fp16_mul_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// ptr moves one past the winner on every grant.
module rr_arbiter
  import fp16_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic                  en,
  output logic [N-1:0]          gnt,
  output logic [id_w(N)-1:0]    gnt_id
);

  localparam int unsigned IdW = id_w(N);

  logic [IdW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic           found;
    logic [IdW-1:0] idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IdW'((32'(ptr_q) + k) % N);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = (32'(gnt_id) == N - 1) ? '0 : gnt_id + IdW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fp16_mul_sched.sv
// Shares one external registered fp16 multiplier among NREQ requesters; tags each
// accepted pair with its requester id and returns results through a credit-guarded FIFO.
module fp16_mul_sched
  import fp16_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [FP16_W*NREQ-1:0]   req_a,
  input  logic [FP16_W*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic [FP16_W-1:0]        mul_a,
  output logic [FP16_W-1:0]        mul_b,
  input  logic [FP16_W-1:0]        mul_x,
  output logic                     rsp_valid,
  output logic [FP16_W-1:0]        rsp_x,
  output logic [id_w(NREQ)-1:0]    rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam int unsigned IdW  = id_w(NREQ);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned SumW = CntW + 1;

  logic [NREQ-1:0] gnt;
  logic [IdW-1:0]  gnt_id;
  logic            accept;
  logic            credit_ok;
  logic            push, pop;
  logic [CntW-1:0] inflight;
  logic [SumW-1:0] occupied;

  tag_t            tag_q [MUL_LAT];
  rsp_t            mem_q [DEPTH];
  rsp_t            head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .en     (credit_ok),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // The arbiter only grants valid requesters, so any grant is an accept.
  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mul_a = req_a[FP16_W*i +: FP16_W];
        mul_b = req_b[FP16_W*i +: FP16_W];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LAT; i++) begin
      inflight = inflight + CntW'(tag_q[i].valid);
    end
  end

  // A pop this cycle frees its slot in time for a same-cycle accept.
  assign pop       = rsp_valid && rsp_ready;
  assign push      = tag_q[MUL_LAT-1].valid;
  assign occupied  = SumW'(count_q) + SumW'(inflight) - SumW'(pop);
  assign credit_ok = occupied < SumW'(DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: accept, id: ID_MAX_W'(gnt_id)};
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (32'(wr_ptr_q) == DEPTH - 1) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (32'(rd_ptr_q) == DEPTH - 1) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{id: tag_q[MUL_LAT-1].id, x: mul_x};
      end
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign rsp_valid = count_q != '0;
  assign rsp_x     = head.x;
  assign rsp_id    = IdW'(head.id);
  assign busy      = rsp_valid || (inflight != '0);

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && count_q == CntW'(DEPTH)));

endmodule

// File: tb/tb_fp16_mul_sched.sv
// Directed bench for fp16_mul_sched: a table-driven multiplier model, queue-based
// scoreboard for responses, and per-cycle grant/operand checks.
module tb_fp16_mul_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic [15:0] mul_a, mul_b, mul_x, rsp_x;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;

  logic [15:0] op_a [4];
  logic [15:0] op_b [4];

  // Hand-computed products for the default operand of each requester.
  localparam logic [15:0] P0 = 16'h4000;  // 1.0 * 2.0
  localparam logic [15:0] P1 = 16'h4A00;  // 3.0 * 4.0
  localparam logic [15:0] P2 = 16'h4400;  // 2.0 * 2.0
  localparam logic [15:0] P3 = 16'h3E00;  // 0.5 * 3.0
  localparam logic [15:0] P5 = 16'h4900;  // 5.0 * 2.0

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] x;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] prod [4];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h3C00, 16'h4000}: return 16'h4000;
      {16'h4200, 16'h4400}: return 16'h4A00;
      {16'h4000, 16'h4000}: return 16'h4400;
      {16'h3800, 16'h4200}: return 16'h3E00;
      {16'h4500, 16'h4000}: return 16'h4900;
      {16'h0000, 16'h0000}: return 16'h0000;
      default:              return 16'h7E00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mul_x <= '0;
    else      mul_x <= fmul(mul_a, mul_b);
  end

  fp16_mul_sched #(
    .NREQ    (4),
    .MUL_LAT (1),
    .DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_x     (mul_x),
    .rsp_valid (rsp_valid),
    .rsp_x     (rsp_x),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every handshake on the response port must match the queue head.
  always @(negedge clk) begin
    if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d x=%h want no response", rsp_id, rsp_x);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_x", 32'(rsp_x), 32'(mon_e.x));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_default_ops();
    op_a[0] = 16'h3C00; op_b[0] = 16'h4000;
    op_a[1] = 16'h4200; op_b[1] = 16'h4400;
    op_a[2] = 16'h4000; op_b[2] = 16'h4000;
    op_a[3] = 16'h3800; op_b[3] = 16'h4200;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic accept_cycle(input string name, input logic [3:0] want_rdy, input int id,
                              input logic [15:0] want_x);
    settle();
    chk({name, "_rdy"}, 32'(req_ready), 32'(want_rdy));
    chk({name, "_mul_a"}, 32'(mul_a), 32'(op_a[id]));
    chk({name, "_mul_b"}, 32'(mul_b), 32'(op_b[id]));
    exp_q.push_back('{id: 2'(id), x: want_x});
    tick();
  endtask

  task automatic idle_cycle(input string name);
    settle();
    chk({name, "_rdy"}, 32'(req_ready), 32'(0));
    chk({name, "_mul_a"}, 32'(mul_a), 32'(0));
    tick();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b0 && exp_q.size() == 0) break;
      tick();
    end
    chk({name, "_busy"}, 32'(busy), 32'(0));
    chk({name, "_left"}, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    prod[0] = P0; prod[1] = P1; prod[2] = P2; prod[3] = P3;
    set_default_ops();
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_rdy", 32'(req_ready), 32'(0));
    chk("rst_mul_a", 32'(mul_a), 32'(0));
    chk("rst_mul_b", 32'(mul_b), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_x", 32'(rsp_x), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    tick();
    tick();
    rst = 1'b1;

    // Single request: response two cycles after the accept.
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    accept_cycle("single", 4'b0001, 0, P0);
    req_valid = '0;
    settle();
    chk("single_lat1_valid", 32'(rsp_valid), 32'(0));
    tick();
    settle();
    chk("single_lat2_valid", 32'(rsp_valid), 32'(1));
    wait_idle("single");

    // Fairness: all valid, one grant per cycle in order 0,1,2,3.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      accept_cycle("fair", 4'(1 << (k % 4)), k % 4, prod[k % 4]);
    end
    req_valid = '0;
    wait_idle("fair");

    // Backpressure: four accepts fill the credit, one pop frees one accept.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      accept_cycle("bp", 4'(1 << k), k, prod[k]);
    end
    for (int k = 0; k < 3; k++) begin
      idle_cycle("bp_full");
    end
    rsp_ready = 1'b1;
    accept_cycle("bp_pop", 4'b0001, 0, P0);
    rsp_ready = 1'b0;
    idle_cycle("bp_refull");
    rsp_ready = 1'b1;
    req_valid = '0;
    wait_idle("bp");

    // Steady push/pop with three entries held; alternating products check order.
    do_reset();
    req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) rsp_ready = 1'b1;
      if (k % 2 == 0) begin
        op_a[1] = 16'h4200; op_b[1] = 16'h4400;
        accept_cycle("pp", 4'b0010, 1, P1);
      end else begin
        op_a[1] = 16'h4500; op_b[1] = 16'h4000;
        accept_cycle("pp", 4'b0010, 1, P5);
      end
    end
    rsp_ready = 1'b0;
    idle_cycle("pp_cnt3");
    set_default_ops();
    rsp_ready = 1'b1;
    req_valid = '0;
    wait_idle("pp");

    // Reset with two products outstanding.
    do_reset();
    req_valid = 4'b0011;
    accept_cycle("mid", 4'b0001, 0, P0);
    accept_cycle("mid", 4'b0010, 1, P1);
    rst       = 1'b0;
    req_valid = '0;
    exp_q.delete();
    settle();
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_rsp_x", 32'(rsp_x), 32'(0));
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("mid_rst_rdy", 32'(req_ready), 32'(0));
    tick();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("mid_post_rsp_valid", 32'(rsp_valid), 32'(0));
      tick();
    end

    // Sparse requests and pointer wrap.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    accept_cycle("wrap3", 4'b1000, 3, P3);
    req_valid = '0;
    idle_cycle("wrap_gap");
    req_valid = 4'b0001;
    accept_cycle("wrap0", 4'b0001, 0, P0);
    req_valid = 4'b0100;
    accept_cycle("wrap2", 4'b0100, 2, P2);
    req_valid = 4'b1001;
    accept_cycle("wrap3b", 4'b1000, 3, P3);
    req_valid = 4'b0011;
    accept_cycle("wrap0b", 4'b0001, 0, P0);
    req_valid = '0;
    wait_idle("wrap");

    chk("end_queue", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
